// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the instruction word into IF/ID,
// and applies decode-resolved branch/jump redirects. It halts on a self-targeting jump.
module fetch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] pc_addr,
  input  logic [31:0]         imem_rdata,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc_plus4,
  input  logic                id_ready,
  input  logic                branch_taken,
  input  logic [15:0]         branch_offset,
  input  logic                jump_valid,
  input  logic [25:0]         jump_target,
  output logic                halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc4_nxt;
  logic                valid_nxt;
  logic [31:0]         instr_nxt;

  logic                adv, accept, self_jump;
  logic [PC_WIDTH-1:0] seq_pc, jump_addr, branch_disp, branch_addr, ifid_pc;

  assign adv    = !ifid_valid || id_ready;
  assign accept = ifid_valid && id_ready;
  assign seq_pc = pc + PC_WIDTH'(4);

  // Targets are word-shifted then truncated to the PC width; no upper-PC concatenation.
  assign jump_addr   = PC_WIDTH'({jump_target, 2'b00});
  assign branch_disp = PC_WIDTH'({{14{branch_offset[15]}}, branch_offset, 2'b00});
  assign branch_addr = ifid_pc_plus4 + branch_disp;
  assign ifid_pc     = ifid_pc_plus4 - PC_WIDTH'(4);
  assign self_jump   = accept && jump_valid && (jump_addr == ifid_pc);

  assign pc_addr = pc;
  assign halted  = (state == HALT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = ifid_valid;
    instr_nxt = ifid_instr;
    pc4_nxt   = ifid_pc_plus4;
    case (state)
      RUN: begin
        // Jump has priority over branch. Any redirect squashes this cycle's wrong-path word.
        if (self_jump) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else if (accept && jump_valid) begin
          pc_nxt    = jump_addr;
          valid_nxt = 1'b0;
        end else if (accept && branch_taken) begin
          pc_nxt    = branch_addr;
          valid_nxt = 1'b0;
        end else if (adv) begin
          instr_nxt = imem_rdata;
          pc4_nxt   = seq_pc;
          valid_nxt = 1'b1;
          pc_nxt    = seq_pc;
        end
      end
      HALT: valid_nxt = 1'b0;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      ifid_valid    <= valid_nxt;
      ifid_instr    <= instr_nxt;
      ifid_pc_plus4 <= pc4_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc_plus4;
  logic        id_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump_valid;
  logic [25:0] jump_target;
  logic        halted;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_pc, m_pc4;
  bit          m_valid, m_halt;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  assign imem_rdata = mem[pc_addr[7:2]];

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .id_ready(id_ready), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target), .halted(halted)
  );

  // Advance the model by one cycle from the current inputs, then clock the DUT
  // and return on the falling edge, where outputs are sampled.
  task automatic tick();
    int tgt;
    if (!rst) begin
      m_pc = 0; m_pc4 = 0; m_valid = 0; m_instr = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (m_valid && id_ready && jump_valid) begin
        tgt = (int'(jump_target) * 4) & 255;
        if (tgt == ((m_pc4 - 4) & 255)) m_halt = 1;
        else m_pc = tgt;
        m_valid = 0;
      end else if (m_valid && id_ready && branch_taken) begin
        m_pc = (m_pc4 + 4 * int'($signed(branch_offset))) & 255;
        m_valid = 0;
      end else if (!m_valid || id_ready) begin
        m_instr = mem[m_pc / 4];
        m_pc4   = (m_pc + 4) & 255;
        m_pc    = m_pc4;
        m_valid = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    id_ready = 1'b1; branch_taken = 1'b0; branch_offset = '0;
    jump_valid = 1'b0; jump_target = '0;
  endtask

  // Reset for two cycles, then run n sequential fetches.
  task automatic reset_and_run(input int n);
    quiet_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b0;
    tick(); tick();
    n_checks++; if (pc_addr !== 8'h00) $display("[TB] FAIL reset_pc got %h exp 00", pc_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b exp 0", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== 32'h0) $display("[TB] FAIL reset_instr got %h exp 0", ifid_instr); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h00) $display("[TB] FAIL reset_pc4 got %h exp 00", ifid_pc_plus4); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted got %b exp 0", halted); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (pc_addr !== 8'h04) $display("[TB] FAIL seq_pc1 got %h exp 04", pc_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL seq_valid1 got %b exp 1", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== mem[0]) $display("[TB] FAIL seq_instr0 got %h exp %h", ifid_instr, mem[0]); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h04) $display("[TB] FAIL seq_pc4_0 got %h exp 04", ifid_pc_plus4); else n_pass++;
    tick();
    n_checks++; if (pc_addr !== 8'h08) $display("[TB] FAIL seq_pc2 got %h exp 08", pc_addr); else n_pass++;
    n_checks++; if (ifid_instr !== mem[1]) $display("[TB] FAIL seq_instr1 got %h exp %h", ifid_instr, mem[1]); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h08) $display("[TB] FAIL seq_pc4_1 got %h exp 08", ifid_pc_plus4); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_addr !== 8'h0C) $display("[TB] FAIL stall_pc got %h exp 0c", pc_addr); else n_pass++;
      n_checks++; if (ifid_instr !== mem[2]) $display("[TB] FAIL stall_instr got %h exp %h", ifid_instr, mem[2]); else n_pass++;
      n_checks++; if (ifid_pc_plus4 !== 8'h0C) $display("[TB] FAIL stall_pc4 got %h exp 0c", ifid_pc_plus4); else n_pass++;
      n_checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL stall_valid got %b exp 1", ifid_valid); else n_pass++;
    end
    id_ready = 1'b1;
    tick();
    n_checks++; if (ifid_instr !== mem[3]) $display("[TB] FAIL unstall_instr got %h exp %h", ifid_instr, mem[3]); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h10) $display("[TB] FAIL unstall_pc4 got %h exp 10", ifid_pc_plus4); else n_pass++;
  endtask

  task automatic test_branch();
    reset_and_run(3);
    branch_taken = 1'b1; branch_offset = 16'h0001;
    tick();
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'h10) $display("[TB] FAIL br_fwd_pc got %h exp 10", pc_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL br_fwd_bubble got %b exp 0", ifid_valid); else n_pass++;
    tick();
    n_checks++; if (ifid_instr !== mem[4]) $display("[TB] FAIL br_fwd_instr got %h exp %h", ifid_instr, mem[4]); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL br_fwd_valid got %b exp 1", ifid_valid); else n_pass++;
    reset_and_run(3);
    branch_taken = 1'b1; branch_offset = 16'hFFFD;
    tick();
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'h00) $display("[TB] FAIL br_back_pc got %h exp 00", pc_addr); else n_pass++;
    tick();
    n_checks++; if (ifid_instr !== mem[0]) $display("[TB] FAIL br_back_instr got %h exp %h", ifid_instr, mem[0]); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h04) $display("[TB] FAIL br_back_pc4 got %h exp 04", ifid_pc_plus4); else n_pass++;
  endtask

  task automatic test_jump_priority();
    reset_and_run(3);
    jump_valid = 1'b1; jump_target = 26'd5; branch_taken = 1'b1; branch_offset = 16'h0001;
    tick();
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'h14) $display("[TB] FAIL jmp_pc got %h exp 14", pc_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL jmp_bubble got %b exp 0", ifid_valid); else n_pass++;
    tick();
    n_checks++; if (ifid_instr !== mem[5]) $display("[TB] FAIL jmp_instr got %h exp %h", ifid_instr, mem[5]); else n_pass++;
    id_ready = 1'b0; jump_valid = 1'b1; jump_target = 26'd5;
    tick();
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'h18) $display("[TB] FAIL jmp_ignored_pc got %h exp 18", pc_addr); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL jmp_ignored_valid got %b exp 1", ifid_valid); else n_pass++;
  endtask

  task automatic test_halt();
    reset_and_run(1);
    jump_valid = 1'b1; jump_target = 26'h3A;
    tick();
    quiet_inputs();
    tick();
    n_checks++; if (ifid_pc_plus4 !== 8'hEC) $display("[TB] FAIL halt_setup_pc4 got %h exp ec", ifid_pc_plus4); else n_pass++;
    jump_valid = 1'b1; jump_target = 26'h3A;
    tick();
    n_checks++; if (halted !== 1'b1) $display("[TB] FAIL halt_flag got %b exp 1", halted); else n_pass++;
    n_checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL halt_valid got %b exp 0", ifid_valid); else n_pass++;
    jump_target = 26'h10; branch_taken = 1'b1; branch_offset = 16'h0004;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (pc_addr !== 8'hEC) $display("[TB] FAIL halt_pc_hold got %h exp ec", pc_addr); else n_pass++;
      n_checks++; if (halted !== 1'b1 || ifid_valid !== 1'b0) $display("[TB] FAIL halt_hold got h=%b v=%b exp h=1 v=0", halted, ifid_valid); else n_pass++;
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'h00) $display("[TB] FAIL halt_reset_pc got %h exp 00", pc_addr); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("[TB] FAIL halt_reset_flag got %b exp 0", halted); else n_pass++;
  endtask

  task automatic test_wrap();
    reset_and_run(1);
    jump_valid = 1'b1; jump_target = 26'h3E;
    tick();
    quiet_inputs();
    n_checks++; if (pc_addr !== 8'hF8) $display("[TB] FAIL wrap_pc0 got %h exp f8", pc_addr); else n_pass++;
    tick();
    n_checks++; if (pc_addr !== 8'hFC) $display("[TB] FAIL wrap_pc1 got %h exp fc", pc_addr); else n_pass++;
    tick();
    n_checks++; if (pc_addr !== 8'h00) $display("[TB] FAIL wrap_pc2 got %h exp 00", pc_addr); else n_pass++;
    n_checks++; if (ifid_instr !== mem[63]) $display("[TB] FAIL wrap_instr got %h exp %h", ifid_instr, mem[63]); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 8'h00) $display("[TB] FAIL wrap_pc4 got %h exp 00", ifid_pc_plus4); else n_pass++;
  endtask

  task automatic test_random();
    quiet_inputs();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) != 0);
      id_ready      = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_offset = 16'($urandom);
      jump_valid    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) jump_target = 26'(((m_pc4 - 4) & 255) / 4);
      else jump_target = 26'($urandom);
      tick();
      n_checks++;
      if (pc_addr !== 8'(m_pc) || ifid_valid !== m_valid || halted !== m_halt ||
          (m_valid && (ifid_instr !== m_instr || ifid_pc_plus4 !== 8'(m_pc4))))
        $display("[TB] FAIL rand_cycle%0d got pc=%h v=%b h=%b i=%h p4=%h exp pc=%h v=%b h=%b i=%h p4=%h",
                 i, pc_addr, ifid_valid, halted, ifid_instr, ifid_pc_plus4,
                 8'(m_pc), m_valid, m_halt, m_instr, 8'(m_pc4));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    quiet_inputs();
    rst = 1'b0;
    test_reset();
    test_stall();
    test_branch();
    test_jump_priority();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core. Holds the program counter, drives the byte address into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. It applies branch and jump redirects resolved in decode, stalls under back-pressure from decode, and halts on a self-targeting jump (the program's terminal "stay" loop).

## Interface
- PC_WIDTH, 8, byte-address width of the PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- pc_addr  out  PC_WIDTH  byte address to the instruction memory; equals the PC register.
- imem_rdata  in  32  instruction word returned combinationally for pc_addr.
- ifid_valid  out  1  IF/ID register holds a live instruction.
- ifid_instr  out  32  captured instruction word.
- ifid_pc_plus4  out  PC_WIDTH  address of the captured instruction + 4.
- id_ready  in  1  decode consumes the IF/ID contents this cycle.
- branch_taken  in  1  decode: instruction in IF/ID is a taken branch.
- branch_offset  in  16  signed word offset of that branch.
- jump_valid  in  1  decode: instruction in IF/ID is a jump.
- jump_target  in  26  jump index field of that instruction.
- halted  out  1  fetch has stopped on a self-jump.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Accept condition: `adv = !ifid_valid || id_ready`. Redirect inputs are sampled only when `ifid_valid && id_ready`; otherwise they are ignored.
- Branch target: `ifid_pc_plus4 + (sign_extend(branch_offset) << 2)`, truncated to PC_WIDTH.
- Jump target: `(jump_target << 2)` truncated to PC_WIDTH. Upper PC bits are not concatenated, because PC_WIDTH ≤ 28.
- Priority when both branch_taken and jump_valid are asserted: jump wins.
- In RUN, each cycle:
  - Self-jump (jump accepted with target == ifid_pc_plus4 − 4): go to HALT. The PC is held, ifid_valid goes to 0 and halted goes to 1.
  - Other redirect (jump or taken branch accepted): PC ← target. ifid_valid ← 0, squashing the wrong-path word fetched this cycle. ifid_instr and ifid_pc_plus4 hold.
  - Otherwise if adv: ifid_instr ← imem_rdata, ifid_pc_plus4 ← PC + 4, ifid_valid ← 1, PC ← PC + 4.
  - Otherwise (stall): PC and all IF/ID outputs hold.
- HALT: PC, ifid_instr and ifid_pc_plus4 hold; ifid_valid = 0; halted = 1. Only reset exits HALT. All redirect inputs are ignored.
- PC arithmetic is modulo 2^PC_WIDTH, so 0xFC + 4 wraps to 0x00 with no error flag.
- pc_addr[1:0] is always 00. All targets are word-shifted and RESET_PC is aligned.

## Timing
- Reset (rst = 0 at an edge): PC = RESET_PC, ifid_valid = 0, ifid_instr = 0, ifid_pc_plus4 = 0, halted = 0, state = RUN. Reset overrides every other input in that cycle, including mid-stall and in HALT.
- Fetch latency: the word at address A is presented on ifid_instr one cycle after pc_addr = A, provided adv holds.
- Redirect penalty: one bubble. The cycle after an accepted redirect, pc_addr = target and ifid_valid = 0. The target instruction appears in IF/ID one cycle later.
- Back-to-back redirects cannot occur, because the bubble blocks sampling.
- Stall: while ifid_valid = 1 and id_ready = 0, all outputs are stable. The cycle after id_ready rises, the next sequential word is captured.
- halted rises in the cycle after the self-jump is accepted and stays high until reset.

## Test plan
- Reset/sequential: hold rst = 0 for 2 cycles with RESET_PC = 0, then release with id_ready = 1.
  - pc_addr goes 0x00, 0x04, 0x08.
  - ifid_valid first rises one cycle after release.
  - ifid_instr = mem[0] with ifid_pc_plus4 = 0x04, then mem[1] with 0x08.
- Stall: drop id_ready for 3 cycles while ifid holds mem[2].
  - pc_addr stays 0x0C; ifid_instr/ifid_pc_plus4 stay mem[2]/0x0C.
  - After release, the next capture is mem[3] with 0x10.
- Branch: branch_taken = 1 with offset = 0x0001 while ifid_pc_plus4 = 0x0C.
  - Next cycle: pc_addr = 0x10 and ifid_valid = 0.
  - The cycle after: ifid_instr = mem[4].
  - Repeat with offset = 0xFFFD: target = 0x00.
- Jump priority: jump_valid = 1 with jump_target = 5 and branch_taken = 1 in the same cycle.
  - Next cycle: pc_addr = 0x14, one bubble.
  - Repeat with id_ready = 0: the redirect is ignored and the PC holds.
- Self-jump halt: ifid holds a jump at 0xE8 (ifid_pc_plus4 = 0xEC) with jump_target = 0x3A.
  - halted = 1 and ifid_valid = 0.
  - pc_addr stays 0xEC for 10 or more cycles while a redirect is forced.
  - rst = 0 then returns pc_addr to 0x00 and halted to 0.
- Wrap: run sequentially from 0xF8.
  - pc_addr goes 0xF8, 0xFC, 0x00.
  - The word fetched at 0xFC is captured with ifid_pc_plus4 = 0x00.
